// File: rtl/pulse_stretcher.sv
// Stretches each request strobe into a WIDTH-cycle high pulse with a GAP-cycle
// low spacer, queueing up to DEPTH requests that arrive while a pulse runs.
module pulse_stretcher #(
   parameter int WIDTH = 4,
   parameter int GAP   = 2,
   parameter int DEPTH = 3
) (
   input  logic       clk_4,
   input  logic       rst_n,
   input  logic       pulse_in,
   input  logic       clear,
   output logic       out,
   output logic       busy,
   output logic [3:0] pending,
   output logic       overflow
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HIGH   = 2'd1,
      GAP_LO = 2'd2
   } state_t;

   localparam logic [7:0] W_LD    = 8'(WIDTH - 1);
   localparam logic [7:0] G_LD    = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);

   state_t     r_state;
   state_t     w_state_nx;
   logic [7:0] r_timer;
   logic [7:0] w_timer_nx;
   logic [3:0] r_pending;
   logic       r_overflow;
   logic       r_out;
   logic       w_more;
   logic       w_start;
   logic       w_inc;
   logic       w_dec;

   // A clear flushes the queue, so the exit decision must not see it.
   assign w_more  = (r_pending != 4'd0) && !clear;
   assign w_start = pulse_in && !clear;

   always_comb begin
      w_state_nx = r_state;
      w_timer_nx = r_timer;
      w_dec      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_more) begin
               w_state_nx = HIGH;
               w_timer_nx = W_LD;
               w_dec      = 1'b1;
            end else if (w_start) begin
               w_state_nx = HIGH;
               w_timer_nx = W_LD;
            end
         end
         HIGH: begin
            if (r_timer != 8'd0) begin
               w_timer_nx = r_timer - 8'd1;
            end else if (GAP > 0) begin
               w_state_nx = GAP_LO;
               w_timer_nx = G_LD;
            end else if (w_more) begin
               w_timer_nx = W_LD;
               w_dec      = 1'b1;
            end else begin
               w_state_nx = IDLE;
            end
         end
         GAP_LO: begin
            if (r_timer != 8'd0) begin
               w_timer_nx = r_timer - 8'd1;
            end else if (w_more) begin
               w_state_nx = HIGH;
               w_timer_nx = W_LD;
               w_dec      = 1'b1;
            end else begin
               w_state_nx = IDLE;
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_timer_nx = 8'd0;
         end
      endcase
   end

   // A strobe in IDLE starts the pulse itself unless a queued one goes first.
   assign w_inc = w_start && ((r_state != IDLE) || w_more);

   always_ff @(posedge clk_4 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_timer <= 8'd0;
         r_out   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_timer <= w_timer_nx;
         r_out   <= (w_state_nx == HIGH);
      end
   end

   always_ff @(posedge clk_4 or negedge rst_n) begin
      if (!rst_n) begin
         r_pending  <= 4'd0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_pending  <= 4'd0;
         r_overflow <= 1'b0;
      end else if (w_inc && !w_dec) begin
         if (r_pending >= DEPTH_C) begin
            r_overflow <= 1'b1;
         end else begin
            r_pending <= r_pending + 4'd1;
         end
      end else if (w_dec && !w_inc) begin
         if (r_pending != 4'd0) begin
            r_pending <= r_pending - 4'd1;
         end
      end
   end

   assign out      = r_out;
   assign busy     = (r_state != IDLE);
   assign pending  = r_pending;
   assign overflow = r_overflow;

endmodule
